// File: rtl/onehot_select_decoder_if.sv
// Select-decoder request/response bundle: single decode and scan requests in,
// registered one-hot beat out.
interface onehot_select_decoder_if #(
  parameter int SEL_W = 4,
  parameter int OUT_W = 1 << SEL_W
);
  logic [SEL_W-1:0] sel_in;
  logic             dec_en;
  logic             scan_start;
  logic [SEL_W-1:0] scan_first;
  logic [SEL_W-1:0] scan_last;
  logic             busy;
  logic             out_valid;
  logic [OUT_W-1:0] onehot_out;
  logic [SEL_W-1:0] out_index;
  logic             scan_done;

  modport master (
    output sel_in, dec_en, scan_start, scan_first, scan_last,
    input  busy, out_valid, onehot_out, out_index, scan_done
  );

  modport slave (
    input  sel_in, dec_en, scan_start, scan_first, scan_last,
    output busy, out_valid, onehot_out, out_index, scan_done
  );
endinterface

// File: rtl/onehot_select_decoder.sv
// Registered binary-to-one-hot decoder with single-shot and wrapping scan modes.
// Define ONEHOT_ZERO_MASK_EN to treat index 0 as a hardwired-zero register.
module onehot_select_decoder #(
  parameter int SEL_W = 4,
  parameter int OUT_W = 1 << SEL_W
) (
  input logic                    clock,
  input logic                    clear,
  onehot_select_decoder_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] index_q, index_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      last_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      index_q  <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      index_q  <= index_d;
      onehot_q <= onehot_d;
    end
  end

  // ptr_q always holds the index of the next beat to issue; SEL_W-bit overflow gives the wrap.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.scan_start) begin
          ptr_d  = bus.scan_first + SEL_W'(1);
          last_d = bus.scan_last;
          if (bus.scan_first != bus.scan_last) state_d = SCAN;
        end
      end
      SCAN: begin
        ptr_d = ptr_q + SEL_W'(1);
        if (ptr_q == last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    index_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.scan_start) begin
          valid_d = 1'b1;
          index_d = bus.scan_first;
          done_d  = (bus.scan_first == bus.scan_last);
          busy_d  = (bus.scan_first != bus.scan_last);
        end else if (bus.dec_en) begin
          valid_d = 1'b1;
          index_d = bus.sel_in;
        end
      end
      SCAN: begin
        valid_d = 1'b1;
        index_d = ptr_q;
        done_d  = (ptr_q == last_q);
        busy_d  = (ptr_q != last_q);
      end
      default: valid_d = 1'b0;
    endcase
`ifdef ONEHOT_ZERO_MASK_EN
    onehot_d = (valid_d && (index_d != '0)) ? (OUT_W'(1) << index_d) : '0;
`else
    onehot_d = valid_d ? (OUT_W'(1) << index_d) : '0;
`endif
  end

  assign bus.busy       = busy_q;
  assign bus.out_valid  = valid_q;
  assign bus.onehot_out = onehot_q;
  assign bus.out_index  = index_q;
  assign bus.scan_done  = done_q;

endmodule

// File: tb/tb_onehot_select_decoder.sv
// Self-checking bench for onehot_select_decoder: directed scenarios then random
// traffic, compared against a beat-queue reference model.
module tb_onehot_select_decoder;
  localparam int SEL_W = 4;
  localparam int OUT_W = 16;

  logic clock;
  logic clear;

  onehot_select_decoder_if #(.SEL_W(SEL_W), .OUT_W(OUT_W)) bus ();

  onehot_select_decoder #(.SEL_W(SEL_W), .OUT_W(OUT_W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int idx;
    bit done;
  } beat_t;

  beat_t pend[$];

  int errors = 0;
  int checks = 0;

  logic             expValid;
  logic             expBusy;
  logic             expDone;
  logic [SEL_W-1:0] expIdx;
  logic [OUT_W-1:0] expOnehot;

  // Reference model: a request expands into its full list of beats, one popped per edge.
  task automatic modelEdge(input bit dec, input int sel, input bit ss, input int first, input int last);
    beat_t b;
    int    n;
    if (pend.size() == 0) begin
      if (ss) begin
        n = (((last - first) % OUT_W) + OUT_W) % OUT_W + 1;
        for (int k = 0; k < n; k++) begin
          b.idx  = (first + k) % OUT_W;
          b.done = (k == n - 1);
          pend.push_back(b);
        end
      end else if (dec) begin
        b.idx  = sel;
        b.done = 1'b0;
        pend.push_back(b);
      end
    end
    if (pend.size() > 0) begin
      b         = pend.pop_front();
      expValid  = 1'b1;
      expIdx    = SEL_W'(b.idx);
      expDone   = b.done;
      expBusy   = (pend.size() > 0);
      expOnehot = '0;
`ifdef ONEHOT_ZERO_MASK_EN
      if (b.idx != 0) expOnehot[b.idx] = 1'b1;
`else
      expOnehot[b.idx] = 1'b1;
`endif
    end else begin
      expValid  = 1'b0;
      expIdx    = '0;
      expDone   = 1'b0;
      expBusy   = 1'b0;
      expOnehot = '0;
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (bus.out_valid === expValid) else begin
      errors++;
      $error("FAIL %s out_valid: got %b expected %b", tag, bus.out_valid, expValid);
    end
    checks++;
    assert (bus.onehot_out === expOnehot) else begin
      errors++;
      $error("FAIL %s onehot_out: got %h expected %h", tag, bus.onehot_out, expOnehot);
    end
    checks++;
    assert (bus.out_index === expIdx) else begin
      errors++;
      $error("FAIL %s out_index: got %0d expected %0d", tag, bus.out_index, expIdx);
    end
    checks++;
    assert (bus.busy === expBusy) else begin
      errors++;
      $error("FAIL %s busy: got %b expected %b", tag, bus.busy, expBusy);
    end
    checks++;
    assert (bus.scan_done === expDone) else begin
      errors++;
      $error("FAIL %s scan_done: got %b expected %b", tag, bus.scan_done, expDone);
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks.
  task automatic applyStimulus(input string tag, input bit dec, input int sel,
                               input bit ss, input int first, input int last);
    bus.dec_en     = dec;
    bus.sel_in     = SEL_W'(sel);
    bus.scan_start = ss;
    bus.scan_first = SEL_W'(first);
    bus.scan_last  = SEL_W'(last);
    modelEdge(dec, sel, ss, first, last);
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 1'b0, 0, 1'b0, 0, 0);
  endtask

  // Pulses clear away from any clock edge and expects outputs to drop at once.
  task automatic applyClear(input string tag);
    #2;
    clear = 1'b1;
    #1;
    pend.delete();
    expValid  = 1'b0;
    expIdx    = '0;
    expDone   = 1'b0;
    expBusy   = 1'b0;
    expOnehot = '0;
    checkOutput(tag);
    #2;
    clear = 1'b0;
  endtask

  initial begin
    clear          = 1'b1;
    bus.dec_en     = 1'b0;
    bus.sel_in     = '0;
    bus.scan_start = 1'b0;
    bus.scan_first = '0;
    bus.scan_last  = '0;
    expValid       = 1'b0;
    expIdx         = '0;
    expDone        = 1'b0;
    expBusy        = 1'b0;
    expOnehot      = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset");
    #3;
    clear = 1'b0;

    applyStimulus("dec_B", 1'b1, 11, 1'b0, 0, 0);
    idleCycle("dec_B_after");

    applyStimulus("scan3_6_b0", 1'b0, 0, 1'b1, 3, 6);
    for (int k = 1; k < 4; k++) idleCycle("scan3_6");
    idleCycle("scan3_6_after");

    applyStimulus("wrap14_1_b0", 1'b0, 0, 1'b1, 14, 1);
    for (int k = 1; k < 4; k++) idleCycle("wrap14_1");
    idleCycle("wrap14_1_after");

    applyStimulus("single_beat", 1'b0, 0, 1'b1, 7, 7);
    applyStimulus("b2b_dec", 1'b1, 9, 1'b0, 0, 0);

    applyStimulus("contend_start", 1'b1, 12, 1'b1, 8, 11);
    applyStimulus("contend_busy", 1'b1, 5, 1'b0, 0, 0);
    applyStimulus("contend_busy", 1'b1, 5, 1'b1, 0, 3);
    applyStimulus("contend_last", 1'b1, 5, 1'b0, 0, 0);
    applyStimulus("contend_b2b", 1'b1, 13, 1'b0, 0, 0);
    idleCycle("contend_after");

    applyStimulus("clr_scan_b0", 1'b0, 0, 1'b1, 0, 15);
    for (int k = 1; k < 5; k++) idleCycle("clr_scan");
    applyClear("clr_mid_scan");
    applyStimulus("clr_then_dec2", 1'b1, 2, 1'b0, 0, 0);
    idleCycle("clr_then_idle");

    applyStimulus("full_wrap_b0", 1'b0, 0, 1'b1, 5, 4);
    for (int k = 1; k < 16; k++) idleCycle("full_wrap");

    for (int d = 0; d < 16; d++) applyStimulus("dec_stream", 1'b1, d, 1'b0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        applyClear("rand_clear");
      end else begin
        applyStimulus("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, OUT_W - 1)),
                      ($urandom_range(0, 5) == 0), int'($urandom_range(0, OUT_W - 1)),
                      int'($urandom_range(0, OUT_W - 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_select_decoder.md
# onehot_select_decoder

Parametrised, registered binary-to-one-hot decoder for register-file and bus-source selection. It supports single-shot decodes and a multi-beat scan mode that emits one one-hot select per cycle over an index range, with wrap-around. Scan mode serves multi-register sequencing such as save/restore of a register block. It sits between the control unit and the register-file enable lines.

## Interface
Parameters:
- `SEL_W`, default 4: width of the binary index.
- `OUT_W`, default `1 << SEL_W`: one-hot width. Must equal `2**SEL_W`.

Ports:
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `clear`, input, 1: reset, asynchronous and active-high.
- `sel_in`, input, `SEL_W`: index for a single decode.
- `dec_en`, input, 1: single decode request.
- `scan_start`, input, 1: scan request.
- `scan_first`, input, `SEL_W`: first index of the scan.
- `scan_last`, input, `SEL_W`: last index of the scan.
- `busy`, output, 1: scan in progress, more beats pending. Requests are ignored while high.
- `out_valid`, output, 1: `onehot_out` is valid this cycle.
- `onehot_out`, output, `OUT_W`: registered one-hot select.
- `out_index`, output, `SEL_W`: binary index of the current beat.
- `scan_done`, output, 1: high on the final beat of a scan.

## Operation
- States: IDLE and SCAN. Reset state is IDLE.
- Reset values: `busy`=0, `out_valid`=0, `onehot_out`=0, `out_index`=0, `scan_done`=0.
- Internal state: scan pointer and last-index registers, both cleared to 0.

Single decode (IDLE, `dec_en`=1, `scan_start`=0):
- Next cycle: `onehot_out` = `1 << sel_in`, `out_index` = `sel_in`, `out_valid`=1 for one cycle.
- `scan_done`=0.

Scan (IDLE, `scan_start`=1):
- `scan_start` has priority over `dec_en` in the same cycle; the decode is dropped.
- Beat count N = `((scan_last - scan_first) mod OUT_W) + 1`, computed modulo `OUT_W` in `SEL_W`-bit arithmetic.
- Beats use ascending indices starting at `scan_first`.
- Wrap-around: after index `OUT_W-1` the next index is 0.
- `scan_first == scan_last` gives a single beat with `scan_done`=1.

SCAN state:
- `dec_en` and `scan_start` are ignored, not queued.
- The pointer advances once per cycle.
- Transition to IDLE when the beat being issued has `out_index == scan_last`.

Output rules:
- Output is all-zero whenever `out_valid`=0.
- When `out_valid`=1, exactly one bit of `onehot_out` is set, except as modified by the Configuration macro.

## Timing
- Latency: request sampled at edge t; first output visible after edge t, i.e. in cycle t+1.
- Scan beat k (k=0..N-1) is visible in cycle t+1+k. `out_valid` stays high for N consecutive cycles.
- `busy` is high in cycles t+1 .. t+N-1, i.e. on every beat except the last. `busy` is 0 for N=1.
- `scan_done` is high only in cycle t+N, coincident with the final beat.
- Back-to-back: a request presented in the final-beat cycle (where `busy`=0) is accepted. Its output follows with no idle cycle in between.
- Single decodes may be issued every cycle, giving one output per cycle.
- Asserting `clear` mid-scan immediately zeroes all outputs and returns to IDLE. Remaining beats are discarded.
- After `clear` deasserts, the first edge may accept a new request.

## Configuration
- Macro: `ONEHOT_ZERO_MASK_EN`.
- Defined: index 0 is treated as a hardwired-zero register. Any beat or decode with `out_index`=0 drives `onehot_out`=0. `out_valid`, `out_index`, `busy` and `scan_done` behave unchanged, so beat counting and timing are identical.
- Undefined: index 0 decodes to `onehot_out` bit 0 like any other index.

## Test plan
- Reset: assert `clear` asynchronously mid-cycle. Required: all outputs go to 0 without waiting for a clock edge, and the block returns to IDLE.
- Single decode (`SEL_W`=4): drive `sel_in`=4'hB with `dec_en` for one cycle. Required next cycle: `onehot_out`=16'h0800, `out_index`=11, `out_valid`=1, `scan_done`=0. Outputs return to 0 the cycle after.
- Scan without wrap: `scan_first`=3, `scan_last`=6. Required: 4 beats 16'h0008, 16'h0010, 16'h0020, 16'h0040. `busy`=1,1,1,0 across the beats; `scan_done` high on the 4th beat only.
- Scan with wrap: `scan_first`=14, `scan_last`=1. Required: indices 14, 15, 0, 1 with `onehot_out` 16'h4000, 16'h8000, 16'h0001, 16'h0002. With `ONEHOT_ZERO_MASK_EN` defined, the third beat is 16'h0000 with `out_valid`=1.
- Contention: `scan_start` and `dec_en` in the same cycle, then `dec_en` with `sel_in`=5 during `busy`. Required: the scan runs, the `sel_in`=5 decode never appears, and `dec_en` issued in the final-beat cycle yields its output in the very next cycle.
- Clear mid-scan: start a scan with `scan_first`=0, `scan_last`=15, then assert `clear` on beat 5. Required: outputs go to 0 immediately. A subsequent single decode of `sel_in`=2 produces 16'h0004 normally.
